// File: rtl/tenc_compl_arbiter.sv
// Round-robin arbiter sharing the TLP completion encoder between the a4lm, cfg and fifo1
// completion sources. Latches one descriptor per grant and tracks the encoder until done or timeout.
module tenc_compl_arbiter #(
    parameter int DESC_W  = 95,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lnk_up,
    input  logic [2:0]            req_valid,
    input  logic [3*DESC_W-1:0]   req_desc,
    output logic [2:0]            req_ack,
    input  logic                  tlp_enc_ready,
    input  logic                  tenc_done,
    output logic                  tenc_req_compl,
    output logic [2:0]            tenc_tc,
    output logic [1:0]            tenc_attr,
    output logic [9:0]            tenc_length,
    output logic [15:0]           tenc_rid,
    output logic [7:0]            tenc_tag,
    output logic [7:0]            tenc_be,
    output logic [12:0]           tenc_addr,
    output logic [2:0]            tenc_compl_code,
    output logic [31:0]           tenc_data,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  timeout_err
);

    // Field order mirrors the descriptor bit layout, data in the top bits.
    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  compl_code;
        logic [12:0] addr;
        logic [7:0]  be;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [9:0]  length;
        logic [1:0]  attr;
        logic [2:0]  tc;
    } desc_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state;
    desc_t [2:0]     src_desc;
    desc_t           desc_q;
    logic [1:0]      last;
    logic [7:0]      cnt;
    logic [1:0]      p0, p1, win;

    for (genvar g = 0; g < 3; g++) begin : g_src
        assign src_desc[g] = desc_t'(req_desc[g*DESC_W +: $bits(desc_t)]);
    end

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Scan last+1, last+2, then last itself.
    always_comb begin
        p0  = nxt(last);
        p1  = nxt(p0);
        win = last;
        if (req_valid[p0])
            win = p0;
        else if (req_valid[p1])
            win = p1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            desc_q         <= '0;
            grant_id       <= 2'd0;
            last           <= 2'd2;
            cnt            <= 8'd0;
            req_ack        <= 3'b000;
            tenc_req_compl <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            req_ack        <= 3'b000;
            tenc_req_compl <= 1'b0;
            timeout_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (lnk_up && tlp_enc_ready && |req_valid) begin
                        desc_q         <= src_desc[win];
                        grant_id       <= win;
                        req_ack        <= 3'b001 << win;
                        tenc_req_compl <= 1'b1;
                        busy           <= 1'b1;
                        cnt            <= 8'd0;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // Link loss abandons the transaction without touching the pointer.
                    if (!lnk_up) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= 8'd0;
                    end else if (tenc_done) begin
                        last  <= grant_id;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= 8'd0;
                    end else if (state == S_WAIT && cnt == 8'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        last        <= grant_id;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        cnt         <= 8'd0;
                    end else begin
                        if (state == S_WAIT)
                            cnt <= cnt + 8'd1;
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign tenc_tc         = desc_q.tc;
    assign tenc_attr       = desc_q.attr;
    assign tenc_length     = desc_q.length;
    assign tenc_rid        = desc_q.rid;
    assign tenc_tag        = desc_q.tag;
    assign tenc_be         = desc_q.be;
    assign tenc_addr       = desc_q.addr;
    assign tenc_compl_code = desc_q.compl_code;
    assign tenc_data       = desc_q.data;

endmodule

// File: tb/tb_tenc_compl_arbiter.sv
// Directed bench for tenc_compl_arbiter: single grant, round-robin, timeout, back-pressure/link, reset.
module tb_tenc_compl_arbiter;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lnk_up = 1'b0;
    logic [2:0]    req_valid = 3'b000;
    logic [284:0]  req_desc;
    logic [2:0]    req_ack;
    logic          tlp_enc_ready = 1'b0;
    logic          tenc_done = 1'b0;
    logic          tenc_req_compl;
    logic [2:0]    tenc_tc;
    logic [1:0]    tenc_attr;
    logic [9:0]    tenc_length;
    logic [15:0]   tenc_rid;
    logic [7:0]    tenc_tag;
    logic [7:0]    tenc_be;
    logic [12:0]   tenc_addr;
    logic [2:0]    tenc_compl_code;
    logic [31:0]   tenc_data;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    logic [94:0]   d0 = '0, d1 = '0, d2 = '0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    assign req_desc = {d2, d1, d0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tenc_compl_arbiter #(.DESC_W(95), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .lnk_up(lnk_up), .req_valid(req_valid), .req_desc(req_desc),
        .req_ack(req_ack), .tlp_enc_ready(tlp_enc_ready), .tenc_done(tenc_done),
        .tenc_req_compl(tenc_req_compl), .tenc_tc(tenc_tc), .tenc_attr(tenc_attr),
        .tenc_length(tenc_length), .tenc_rid(tenc_rid), .tenc_tag(tenc_tag), .tenc_be(tenc_be),
        .tenc_addr(tenc_addr), .tenc_compl_code(tenc_compl_code), .tenc_data(tenc_data),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [94:0] mk(input logic [2:0] tc, input logic [1:0] attr,
                                       input logic [9:0] len, input logic [15:0] rid,
                                       input logic [7:0] tag, input logic [7:0] be,
                                       input logic [12:0] addr, input logic [2:0] cc,
                                       input logic [31:0] data);
        return {data, cc, addr, be, tag, rid, len, attr, tc};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        checks++; if (busy !== 1'b0 || req_ack !== 3'b000 || tenc_req_compl !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b ack=%b req=%b to=%b, want all 0", busy, req_ack, tenc_req_compl, timeout_err);
        end
        checks++; if (grant_id !== 2'd0 || tenc_tag !== 8'h0 || tenc_data !== 32'h0 || tenc_rid !== 16'h0) begin
            errors++; $display("FAIL reset_fields: gid=%0d tag=%h data=%h rid=%h, want 0", grant_id, tenc_tag, tenc_data, tenc_rid);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        lnk_up = 1'b1; tlp_enc_ready = 1'b1;
        d0 = mk(3'd5, 2'd2, 10'd1, 16'h0100, 8'h10, 8'h0F, 13'h0040, 3'd0, 32'hF0B6A5C4);
        req_valid = 3'b001;
        tick;
        checks++; if (req_ack !== 3'b001 || tenc_req_compl !== 1'b1 || grant_id !== 2'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: ack=%b req=%b gid=%0d busy=%b, want 001 1 0 1", req_ack, tenc_req_compl, grant_id, busy);
        end
        checks++; if (tenc_tag !== 8'h10 || tenc_data !== 32'hF0B6A5C4 || tenc_tc !== 3'd5 || tenc_attr !== 2'd2 ||
                      tenc_length !== 10'd1 || tenc_rid !== 16'h0100 || tenc_be !== 8'h0F || tenc_addr !== 13'h0040 ||
                      tenc_compl_code !== 3'd0) begin
            errors++; $display("FAIL single_fields: tag=%h data=%h tc=%0d rid=%h addr=%h, want 10 F0B6A5C4 5 0100 0040",
                               tenc_tag, tenc_data, tenc_tc, tenc_rid, tenc_addr);
        end
        req_valid = 3'b000;
        tick;
        checks++; if (req_ack !== 3'b000 || tenc_req_compl !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_pulse_len: ack=%b req=%b busy=%b, want 000 0 1", req_ack, tenc_req_compl, busy);
        end
        repeat (4) tick;
        tenc_done = 1'b1;
        tick;
        tenc_done = 1'b0;
        checks++; if (busy !== 1'b0 || tenc_tag !== 8'h10) begin
            errors++; $display("FAIL single_done: busy=%b tag=%h, want 0 10", busy, tenc_tag);
        end
    endtask

    task automatic test_round_robin;
        int exp_order [4] = '{0, 1, 2, 0};
        int acks [3] = '{0, 0, 0};
        int prev = 0;
        reset = 1'b1; tick; reset = 1'b0;
        d0 = mk(3'd0, 2'd0, 10'd1, 16'h0001, 8'hA0, 8'hFF, 13'h0, 3'd0, 32'h000000A0);
        d1 = mk(3'd1, 2'd0, 10'd1, 16'h0002, 8'hA1, 8'hFF, 13'h0, 3'd0, 32'h000000A1);
        d2 = mk(3'd2, 2'd0, 10'd1, 16'h0003, 8'hA2, 8'hFF, 13'h0, 3'd0, 32'h000000A2);
        req_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            int b = 0;
            tick;
            tenc_done = 1'b0;
            while (tenc_req_compl !== 1'b1 && b < 20) begin tick; b++; end
            checks++; if (tenc_req_compl !== 1'b1) begin
                errors++; $display("FAIL rr_wait_pulse: no tenc_req_compl within 20 cycles (round %0d)", n);
            end
            checks++; if (grant_id !== 2'(exp_order[n]) || req_ack !== (3'b001 << exp_order[n]) ||
                          tenc_tag !== 8'(8'hA0 + exp_order[n])) begin
                errors++; $display("FAIL rr_grant: round %0d gid=%0d ack=%b tag=%h, want gid %0d", n, grant_id, req_ack, tenc_tag, exp_order[n]);
            end
            if (n > 0) begin
                checks++; if (cyc - prev != 5) begin
                    errors++; $display("FAIL rr_spacing: pulse gap %0d, want 5", cyc - prev);
                end
            end
            prev = cyc;
            for (int s = 0; s < 3; s++) if (req_ack[s]) acks[s]++;
            repeat (3) tick;
            tenc_done = 1'b1;
            tick;
            tenc_done = 1'b0;
        end
        req_valid = 3'b000;
        checks++; if (acks[0] != 2 || acks[1] != 1 || acks[2] != 1) begin
            errors++; $display("FAIL rr_ack_count: %0d %0d %0d, want 2 1 1", acks[0], acks[1], acks[2]);
        end
    endtask

    task automatic test_timeout;
        d1 = mk(3'd0, 2'd1, 10'd2, 16'h0A0B, 8'hB1, 8'h0F, 13'h0100, 3'd2, 32'h12345678);
        d2 = mk(3'd0, 2'd0, 10'd1, 16'h0C0D, 8'hB2, 8'hFF, 13'h0200, 3'd0, 32'h9ABCDEF0);
        req_valid = 3'b010;
        tick;
        checks++; if (grant_id !== 2'd1 || req_ack !== 3'b010 || tenc_compl_code !== 3'd2) begin
            errors++; $display("FAIL to_grant: gid=%0d ack=%b cc=%0d, want 1 010 2", grant_id, req_ack, tenc_compl_code);
        end
        req_valid = 3'b000;
        repeat (8) tick;
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_early: to=%b busy=%b at issue+8, want 0 1", timeout_err, busy);
        end
        tick;
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL to_pulse: to=%b busy=%b at issue+9, want 1 0", timeout_err, busy);
        end
        req_valid = 3'b110;
        tick;
        checks++; if (timeout_err !== 1'b0 || grant_id !== 2'd2 || req_ack !== 3'b100 || tenc_tag !== 8'hB2) begin
            errors++; $display("FAIL to_next: to=%b gid=%0d ack=%b tag=%h, want 0 2 100 B2", timeout_err, grant_id, req_ack, tenc_tag);
        end
        req_valid = 3'b000;
        tick;
        tenc_done = 1'b1;
        tick;
        tenc_done = 1'b0;
    endtask

    task automatic test_backpressure_link;
        logic seen;
        d1 = mk(3'd3, 2'd0, 10'd4, 16'h1111, 8'hC1, 8'hF0, 13'h0010, 3'd1, 32'h55AA55AA);
        req_valid = 3'b010;
        tlp_enc_ready = 1'b0;
        seen = 1'b0;
        repeat (20) begin tick; if (req_ack !== 3'b000 || tenc_req_compl !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin
            errors++; $display("FAIL bp_not_ready: activity seen with tlp_enc_ready=0, want none");
        end
        tlp_enc_ready = 1'b1; lnk_up = 1'b0;
        seen = 1'b0;
        repeat (20) begin tick; if (req_ack !== 3'b000 || tenc_req_compl !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin
            errors++; $display("FAIL bp_link_down: activity seen with lnk_up=0, want none");
        end
        lnk_up = 1'b1;
        tick;
        checks++; if (req_ack !== 3'b010 || tenc_req_compl !== 1'b1 || grant_id !== 2'd1 || tenc_tag !== 8'hC1) begin
            errors++; $display("FAIL bp_release: ack=%b req=%b gid=%0d tag=%h, want 010 1 1 C1", req_ack, tenc_req_compl, grant_id, tenc_tag);
        end
        req_valid = 3'b000;
        tick; tick;
        lnk_up = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL link_drop: busy=%b to=%b, want 0 0", busy, timeout_err);
        end
        lnk_up = 1'b1;
        seen = 1'b0;
        repeat (10) begin tick; if (timeout_err !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin
            errors++; $display("FAIL link_drop_quiet: timeout_err or busy after link drop, want none");
        end
        // Pointer must still be 2 after the aborted grant, so source 0 wins.
        req_valid = 3'b111;
        tick;
        checks++; if (grant_id !== 2'd0 || req_ack !== 3'b001) begin
            errors++; $display("FAIL link_drop_ptr: gid=%0d ack=%b, want 0 001", grant_id, req_ack);
        end
        req_valid = 3'b000;
        tick;
        tenc_done = 1'b1;
        tick;
        tenc_done = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        d2 = mk(3'd7, 2'd3, 10'h3FF, 16'hFFEE, 8'hD2, 8'hAA, 13'h1FFF, 3'd4, 32'hDEADBEEF);
        req_valid = 3'b100;
        tick;
        checks++; if (grant_id !== 2'd2 || tenc_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rst_pre_grant: gid=%0d data=%h, want 2 DEADBEEF", grant_id, tenc_data);
        end
        req_valid = 3'b000;
        tick; tick;
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || tenc_tag !== 8'h0 || tenc_data !== 32'h0 || tenc_addr !== 13'h0) begin
            errors++; $display("FAIL rst_async: busy=%b gid=%0d tag=%h data=%h addr=%h, want all 0", busy, grant_id, tenc_tag, tenc_data, tenc_addr);
        end
        tick;
        reset = 1'b0;
        tick;
        checks++; if (tenc_req_compl !== 1'b0 || req_ack !== 3'b000 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_no_pulse: req=%b ack=%b to=%b, want 0 000 0", tenc_req_compl, req_ack, timeout_err);
        end
        req_valid = 3'b110;
        tick;
        checks++; if (grant_id !== 2'd1 || req_ack !== 3'b010 || tenc_req_compl !== 1'b1) begin
            errors++; $display("FAIL rst_ptr: gid=%0d ack=%b req=%b, want 1 010 1", grant_id, req_ack, tenc_req_compl);
        end
        req_valid = 3'b000;
        tick;
        tenc_done = 1'b1;
        tick;
        tenc_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_backpressure_link();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
